writeback_buffer: RTL and testbench
===================================

# writeback_buffer

Buffers register writebacks from the EX and MEM stages and drains them, one per cycle, into the register file's single write port (`wb_en`/`wb_dest`/`wb_value`). It sits directly upstream of the register file. It also reports read-after-write hazards to the ID stage for any source register with a write still queued.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of two, ≥ 2
- DATA_W, 32 — equals `REGISTER_FILE_LEN`
- ADDR_W, 4 — equals `REGISTER_FILE_ADDRESS_LEN`

Ports:
- clk  in  1  — single clock; all state updates on rising edge
- rst_n  in  1  — asynchronous, active-low reset
- mem_valid  in  1  — MEM stage has a writeback (older in program order)
- mem_dest  in  ADDR_W  — MEM destination register
- mem_value  in  DATA_W  — MEM write value
- ex_valid  in  1  — EX stage has a writeback (younger)
- ex_dest  in  ADDR_W  — EX destination register
- ex_value  in  DATA_W  — EX write value
- in_ready  out  1  — buffer can accept up to two entries this cycle
- wb_en  out  1  — register-file write enable (registered)
- wb_dest  out  ADDR_W  — register-file write address (registered)
- wb_value  out  DATA_W  — register-file write data (registered)
- src_1, src_2  in  ADDR_W  — ID-stage source addresses
- src_1_used, src_2_used  in  1  — source is actually read
- hazard  out  1  — stall ID; combinational
- count  out  $clog2(DEPTH)+1  — entries currently queued, for debug

## Operation
- `in_ready` is 1 when `count <= DEPTH-2`, computed combinationally from the current count. It is therefore a conservative two-slot guarantee.
- **Push rule.** An input is accepted on a rising edge when its valid signal and `in_ready` are both 1.
  - If both inputs are accepted, MEM is written at tail and EX at tail+1.
  - If only one is accepted, it is written at tail.
- **Upstream hold.** When `in_ready` is 0, upstream holds its valid signal and data and stalls. The buffer ignores inputs in that cycle.
- **Pop rule.** On each rising edge with `count > 0`, the head entry is loaded into the output registers with `wb_en` set to 1. With `count == 0`, `wb_en` is set to 0 and `wb_dest`/`wb_value` keep their previous values.
- **Count update.** Next count = count + pushes − pop. Push and pop in the same cycle are both legal. An input arriving into an empty buffer is not popped in the same edge.
- **Pointers.** Head and tail pointers wrap modulo DEPTH.
- **Hazard.** `hazard = (src_1_used && match(src_1)) || (src_2_used && match(src_2))`.
  - `match(a)` is 1 if any occupied FIFO entry has dest == a.
  - The entry in the output registers is excluded: the register file writes it on the negedge of the same cycle, and its combinational read returns the new value before the next rising edge.
  - Entries in EX/MEM that have not yet been pushed are not covered. The existing hazard logic handles them.
- Duplicate destinations in the queue are legal. Program order is preserved, so the youngest write lands last.

## Timing
- **Reset** (rst_n = 0, asynchronous): count = 0, head = tail = 0, `wb_en` = 0, `wb_dest` = 0, `wb_value` = 0. `in_ready` = 1 and `hazard` = 0 follow combinationally.
- **Reset mid-operation:** all queued entries are discarded immediately. No partial write is emitted after reset.
- **Latency:** an entry pushed at edge k into an empty buffer appears on `wb_*` after edge k+1. The register file writes it at the negedge in cycle k+1.
- **Throughput:** one writeback per cycle. A sustained two-per-cycle input fills the buffer and deasserts `in_ready`.
- **Full:** count = DEPTH−1 or DEPTH gives `in_ready` = 0. A pop in that cycle does not re-enable `in_ready` until the next cycle.
- **Empty:** `wb_en` drops to 0 on the edge after the last pop.

## Structure
- `REGISTER_FILE_LEN`, `REGISTER_FILE_ADDRESS_LEN`, and a new `WB_BUFFER_DEPTH` belong in the shared `Constants.v`.
- The storage array with head/tail/count logic is a natural sub-module, `wb_fifo_2w1r` (2-write, 1-read).
- Hazard comparators live in the top module and need per-entry dest and occupancy visibility from the FIFO.

## Test plan
- **Single write:** reset, then mem_valid=1, mem_dest=3, mem_value=0xDEAD for one cycle. Required: `wb_en`=1, `wb_dest`=3, `wb_value`=0xDEAD exactly one cycle after acceptance, then `wb_en`=0.
- **Dual push ordering:** mem (dest 5, 0x11) and ex (dest 5, 0x22) pushed in the same cycle. Required: `wb_*` emits dest 5/0x11, then dest 5/0x22 on consecutive cycles.
- **Backpressure:** both valids held for 4 cycles with DEPTH=4. Required: `in_ready` falls when count reaches 3, no entry is lost or duplicated, and all 8 values drain in order.
- **Hazard:** queue dest 7 behind a full head and drive src_1=7, src_1_used=1. Required: `hazard`=1 while 7 is in the FIFO, and `hazard`=0 in the cycle it sits in the output registers. With src_1_used=0, `hazard`=0 throughout.
- **Wrap-around:** 10 alternating single pushes with concurrent pops. Required: pointers wrap, output order matches input order, and count never exceeds DEPTH.
- **Reset mid-operation:** assert rst_n=0 with 3 entries queued and `wb_en`=1. Required: `wb_en`=0 and count=0 immediately. After release, no stale entries are emitted.

Source files
------------

// File: rtl/writeback_buffer_pkg.sv
// writeback_buffer_pkg: shared register-file constants and sizing helpers for the writeback buffer.
// Contents: REGISTER_FILE_LEN (data width), REGISTER_FILE_ADDRESS_LEN (address width),
//           WB_BUFFER_DEPTH (default FIFO depth), cnt_w() (occupancy counter width).
package writeback_buffer_pkg;

    localparam int REGISTER_FILE_LEN         = 32;
    localparam int REGISTER_FILE_ADDRESS_LEN = 4;
    localparam int WB_BUFFER_DEPTH           = 4;

    // Counter must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/writeback_buffer_if.sv
// writeback_buffer_if: bundles the EX/MEM writeback inputs, register-file write port and ID hazard signals.
// Signals: mem_valid/mem_dest/mem_value (older writeback), ex_valid/ex_dest/ex_value (younger writeback),
//          in_ready (two-slot guarantee), wb_en/wb_dest/wb_value (register-file write port),
//          src_1/src_2 + src_1_used/src_2_used (ID sources), hazard (stall ID), count (occupancy).
// Modports: master drives the pipeline side, slave is the buffer itself.
interface writeback_buffer_if import writeback_buffer_pkg::*; #(
    parameter int DEPTH  = WB_BUFFER_DEPTH,
    parameter int DATA_W = REGISTER_FILE_LEN,
    parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN
);
    localparam int CW = cnt_w(DEPTH);

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_value;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_dest;
    logic [DATA_W-1:0] ex_value;
    logic              in_ready;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_value;
    logic [ADDR_W-1:0] src_1;
    logic [ADDR_W-1:0] src_2;
    logic              src_1_used;
    logic              src_2_used;
    logic              hazard;
    logic [CW-1:0]     count;

    modport master (
        output mem_valid, mem_dest, mem_value, ex_valid, ex_dest, ex_value,
        output src_1, src_2, src_1_used, src_2_used,
        input  in_ready, wb_en, wb_dest, wb_value, hazard, count
    );

    modport slave (
        input  mem_valid, mem_dest, mem_value, ex_valid, ex_dest, ex_value,
        input  src_1, src_2, src_1_used, src_2_used,
        output in_ready, wb_en, wb_dest, wb_value, hazard, count
    );

endinterface

// File: rtl/wb_fifo_2w1r.sv
// wb_fifo_2w1r: circular FIFO with two write ports (a = older, b = younger) and one read port.
// Ports: clk, rst_n (async active-low); push_a/a_dest/a_value, push_b/b_dest/b_value (writes);
//        pop (consume head); head_dest/head_value (head entry); count (occupancy);
//        occupied/dests (per-slot occupancy and destination, for hazard comparison).
module wb_fifo_2w1r import writeback_buffer_pkg::*; #(
    parameter int DEPTH  = WB_BUFFER_DEPTH,
    parameter int DATA_W = REGISTER_FILE_LEN,
    parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_a,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_value,
    input  logic              push_b,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_value,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_dest,
    output logic [DATA_W-1:0] head_value,
    output logic [CW-1:0]     count,
    output logic [DEPTH-1:0]  occupied,
    output logic [ADDR_W-1:0] dests [DEPTH]
);
    logic [ADDR_W-1:0] dest_q  [DEPTH];
    logic [DATA_W-1:0] value_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     tail_next;
    logic [PW-1:0]     offset [DEPTH];
    logic [1:0]        n_push;
    logic              take;

    assign n_push    = {1'b0, push_a} + {1'b0, push_b};
    assign take      = pop && (count != '0);
    assign tail_next = tail + PW'(1);

    assign head_dest  = dest_q[head];
    assign head_value = value_q[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(take);
            tail  <= tail + PW'(n_push);
            count <= count + CW'(n_push) - CW'(take);
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by head/count.
    // A lone push (from either port) goes to tail; a pair puts the younger at tail+1.
    always_ff @(posedge clk) begin
        if (push_a || push_b) begin
            dest_q[tail]  <= push_a ? a_dest : b_dest;
            value_q[tail] <= push_a ? a_value : b_value;
        end
        if (push_a && push_b) begin
            dest_q[tail_next]  <= b_dest;
            value_q[tail_next] <= b_value;
        end
    end

    // A slot is occupied when its distance from head (mod DEPTH) is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign offset[g]   = PW'(g) - head;
        assign occupied[g] = {1'b0, offset[g]} < count;
        assign dests[g]    = dest_q[g];
    end

endmodule

// File: rtl/writeback_buffer.sv
// writeback_buffer: queues EX/MEM writebacks and drains one per cycle into the register-file write port,
// flagging read-after-write hazards for ID sources that still have a queued write.
// Ports: clk, rst_n (async active-low), bus (writeback_buffer_if.slave: inputs, wb port, hazard, count).
module writeback_buffer import writeback_buffer_pkg::*; #(
    parameter int DEPTH  = WB_BUFFER_DEPTH,
    parameter int DATA_W = REGISTER_FILE_LEN,
    parameter int ADDR_W = REGISTER_FILE_ADDRESS_LEN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    writeback_buffer_if.slave        bus
);
    localparam int CW = cnt_w(DEPTH);

    logic              acc_mem;
    logic              acc_ex;
    logic              pop;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_value;
    logic [DEPTH-1:0]  occupied;
    logic [ADDR_W-1:0] dests [DEPTH];
    logic              hit_1;
    logic              hit_2;

    // Two free slots guaranteed, so both inputs can always be taken together.
    assign bus.in_ready = bus.count <= CW'(DEPTH - 2);
    assign acc_mem      = bus.mem_valid && bus.in_ready;
    assign acc_ex       = bus.ex_valid && bus.in_ready;
    assign pop          = bus.count != '0;

    wb_fifo_2w1r #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_a     (acc_mem),
        .a_dest     (bus.mem_dest),
        .a_value    (bus.mem_value),
        .push_b     (acc_ex),
        .b_dest     (bus.ex_dest),
        .b_value    (bus.ex_value),
        .pop        (pop),
        .head_dest  (head_dest),
        .head_value (head_value),
        .count      (bus.count),
        .occupied   (occupied),
        .dests      (dests)
    );

    // Dest/value hold their last written contents while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wb_en    <= 1'b0;
            bus.wb_dest  <= '0;
            bus.wb_value <= '0;
        end else begin
            bus.wb_en <= pop;
            if (pop) begin
                bus.wb_dest  <= head_dest;
                bus.wb_value <= head_value;
            end
        end
    end

    // The entry in the output registers is left out: the register file
    // commits it on the falling edge, before ID's read is needed.
    always_comb begin
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_1 = hit_1 | (occupied[i] && (dests[i] == bus.src_1));
            hit_2 = hit_2 | (occupied[i] && (dests[i] == bus.src_2));
        end
    end

    assign bus.hazard = (bus.src_1_used && hit_1) || (bus.src_2_used && hit_2);

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: scoreboard bench for writeback_buffer (reset, single, dual, backpressure, hazard, wrap, mid reset).
module tb_writeback_buffer;
    import writeback_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;

    typedef struct packed {
        logic [AW-1:0] d;
        logic [DW-1:0] v;
    } ent_t;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b0;
    int            errors = 0;
    int            checks = 0;
    int            mcnt   = 0;
    logic          exp_en = 1'b0;
    logic [AW-1:0] exp_d  = '0;
    logic [DW-1:0] exp_v  = '0;
    logic          rdy;
    ent_t          sb[$];

    writeback_buffer_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus();

    writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // One clock of stimulus; the model predicts the write port after the edge.
    task automatic cycle(input logic mv, input logic [AW-1:0] md, input logic [DW-1:0] mval,
                         input logic ev, input logic [AW-1:0] ed, input logic [DW-1:0] evl);
        ent_t e;
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_value = mval;
        bus.ex_valid  = ev;
        bus.ex_dest   = ed;
        bus.ex_value  = evl;
        rdy = mcnt <= DEPTH - 2;
        @(posedge clk);
        exp_en = mcnt > 0;
        if (exp_en) begin
            e = sb.pop_front();
            exp_d = e.d;
            exp_v = e.v;
        end
        if (mv && rdy) sb.push_back({md, mval});
        if (ev && rdy) sb.push_back({ed, evl});
        mcnt = mcnt + int'(mv && rdy) + int'(ev && rdy) - int'(exp_en);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic model_reset();
        mcnt = 0;
        sb.delete();
        exp_en = 1'b0;
        exp_d = '0;
        exp_v = '0;
    endtask

    task automatic test_reset();
        bus.mem_valid = 0; bus.mem_dest = 0; bus.mem_value = 0;
        bus.ex_valid = 0; bus.ex_dest = 0; bus.ex_value = 0;
        bus.src_1 = 0; bus.src_2 = 0; bus.src_1_used = 0; bus.src_2_used = 0;
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.wb_en !== 1'b0 || bus.wb_dest !== 4'd0 || bus.wb_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_wb: got en=%b dest=%0d value=%h, want 0/0/0", bus.wb_en, bus.wb_dest, bus.wb_value);
        end
        checks++;
        if (bus.count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", bus.count);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_hazard: got %b want 0", bus.hazard);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic test_single_write();
        cycle(1'b1, 4'd3, 32'hDEAD, 1'b0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) idle();
            checks++;
            if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                errors++;
                $display("FAIL single_wb step %0d: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                         k, bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
            end
        end
        checks++;
        if (bus.wb_dest !== 4'd3 || bus.wb_value !== 32'hDEAD || bus.wb_en !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: got en=%b dest=%0d value=%h, want en=0 dest=3 value=0000dead",
                     bus.wb_en, bus.wb_dest, bus.wb_value);
        end
    endtask

    task automatic test_dual_push();
        cycle(1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) idle();
            checks++;
            if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                errors++;
                $display("FAIL dual_wb step %0d: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                         k, bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
            end
            checks++;
            if (bus.count !== 3'(mcnt)) begin
                errors++;
                $display("FAIL dual_count step %0d: got %0d want %0d", k, bus.count, mcnt);
            end
        end
    endtask

    task automatic test_backpressure();
        int i = 0;
        int guard = 0;
        while (i < 4 && guard < 40) begin
            checks++;
            if (bus.in_ready !== (mcnt <= DEPTH - 2)) begin
                errors++;
                $display("FAIL bp_in_ready count=%0d: got %b want %b", mcnt, bus.in_ready, mcnt <= DEPTH - 2);
            end
            cycle(1'b1, 4'(2 * i), 32'hB000_0000 + 32'(2 * i), 1'b1, 4'(2 * i + 1), 32'hB000_0000 + 32'(2 * i + 1));
            if (rdy) i++;
            guard++;
            checks++;
            if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                errors++;
                $display("FAIL bp_wb: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                         bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
            end
            checks++;
            if (bus.count !== 3'(mcnt)) begin
                errors++;
                $display("FAIL bp_count: got %0d want %0d", bus.count, mcnt);
            end
        end
        checks++;
        if (i != 4) begin
            errors++;
            $display("FAIL bp_accept: got %0d pairs accepted want 4", i);
        end
        for (int k = 0; k < 8; k++) begin
            idle();
            checks++;
            if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                errors++;
                $display("FAIL bp_drain: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                         bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
            end
        end
    endtask

    task automatic test_hazard();
        logic [3:0] want;
        for (int p = 0; p < 3; p++) begin
            bus.src_1      = (p == 2) ? 4'd2 : 4'd7;
            bus.src_2      = (p == 2) ? 4'd7 : 4'd2;
            bus.src_1_used = (p == 0);
            bus.src_2_used = (p == 2);
            want           = (p == 1) ? 4'b0000 : 4'b0011;
            cycle(1'b1, 4'd1, 32'hA1, 1'b1, 4'd7, 32'hA7);
            for (int k = 0; k < 4; k++) begin
                if (k > 0) idle();
                checks++;
                if (bus.hazard !== want[k]) begin
                    errors++;
                    $display("FAIL hazard pass %0d step %0d: got %b want %b", p, k, bus.hazard, want[k]);
                end
                checks++;
                if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                    errors++;
                    $display("FAIL hazard_wb pass %0d step %0d: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                             p, k, bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
                end
            end
        end
        bus.src_1_used = 0;
        bus.src_2_used = 0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 13; k++) begin
            if (k < 10 && k % 2 == 0) cycle(1'b1, 4'(k), 32'hC000_0000 + 32'(k), 1'b0, '0, '0);
            else if (k < 10) cycle(1'b0, '0, '0, 1'b1, 4'(k), 32'hC000_0000 + 32'(k));
            else idle();
            checks++;
            if (bus.wb_en !== exp_en || bus.wb_dest !== exp_d || bus.wb_value !== exp_v) begin
                errors++;
                $display("FAIL wrap_wb step %0d: got en=%b dest=%0d value=%h, want en=%b dest=%0d value=%h",
                         k, bus.wb_en, bus.wb_dest, bus.wb_value, exp_en, exp_d, exp_v);
            end
            checks++;
            if (bus.count !== 3'(mcnt) || bus.count > 3'(DEPTH)) begin
                errors++;
                $display("FAIL wrap_count step %0d: got %0d want %0d", k, bus.count, mcnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 4'd8, 32'hE8, 1'b1, 4'd9, 32'hE9);
        cycle(1'b1, 4'd10, 32'hEA, 1'b1, 4'd11, 32'hEB);
        checks++;
        if (bus.wb_en !== 1'b1 || bus.count !== 3'd3) begin
            errors++;
            $display("FAIL mid_setup: got en=%b count=%0d want en=1 count=3", bus.wb_en, bus.count);
        end
        rst_n = 1'b0;
        bus.mem_valid = 0;
        bus.ex_valid = 0;
        #1;
        checks++;
        if (bus.wb_en !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got en=%b count=%0d in_ready=%b want 0/0/1", bus.wb_en, bus.count, bus.in_ready);
        end
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            idle();
            checks++;
            if (bus.wb_en !== 1'b0 || bus.count !== 3'd0) begin
                errors++;
                $display("FAIL mid_stale step %0d: got en=%b count=%0d want en=0 count=0", k, bus.wb_en, bus.count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_dual_push();
        test_backpressure();
        test_hazard();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
